corr_sequencer: RTL
===================

Name: corr_sequencer

Overview:
Top-level sequencer for the time-delay correlation datapath. It clears the correlator, requests a capture of both sample buffers, and runs the correlator by driving its 3-bit topState command. It then waits for the correlator's finished flag, with a timeout, and latches the peak. The peak index is converted to a signed lag and handed to the display/SPI side over a valid/ack handshake.

Parameters:
N_SAMPLES, 2000, samples per channel; correlation output length is 2*N_SAMPLES-1
IDX_W, 12, width of correlator peak index
RES_W, 36, width of correlator peak value
TMO_W, 24, width of run timeout counter
TIMEOUT_CYCLES, 24'd9000000, max RUN cycles before abort (full correlation is about 8.0M cycles)
CLEAR_CYCLES, 4, cycles topState is held at 000 before capture

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin one measurement
cap_req  output  1  held high while sample buffers must capture
cap_done  input  1  pulse/level from buffers: both channels full
topState  output  3  correlator command: 000 clear, 001 hold, 010 run
corr_finished  input  1  correlator done flag
corr_maxResult  input  RES_W  correlator peak value
corr_maxIndex  input  IDX_W  correlator peak index
res_valid  output  1  result available
res_ack  input  1  consumer accepts result
res_peak  output  RES_W  latched peak value
res_lag  output  IDX_W+1  signed lag = corr_maxIndex - (N_SAMPLES-1)
busy  output  1  high in any state except IDLE and PRESENT
timeout_err  output  1  sticky: last run aborted by timeout

Behaviour:
- Reset values: state IDLE, topState 000, cap_req 0, res_valid 0, res_peak 0, res_lag 0, busy 0, timeout_err 0, all counters 0.
- FSM states and transitions, all registered on posedge clk:
  - IDLE: topState 001. start=1 -> CLEAR and clear timeout_err.
  - CLEAR: topState 000. Counts CLEAR_CYCLES cycles -> CAPTURE.
  - CAPTURE: topState 001, cap_req 1. cap_done=1 -> RUN (cap_req drops the same edge).
  - RUN: topState 010. Timeout counter increments each cycle.
    - corr_finished is qualified only after 2 cycles in RUN (masks a stale flag).
    - Qualified finished -> LATCH.
    - Counter == TIMEOUT_CYCLES-1 -> ABORT.
  - LATCH: topState 001. Capture corr_maxResult and corr_maxIndex -> PRESENT.
  - PRESENT: res_valid 1, outputs stable. res_ack=1 -> IDLE (res_valid low next cycle).
  - ABORT: topState 000 for one cycle; timeout_err set; res_valid stays 0 -> IDLE.
- Latency: LATCH occupies exactly 1 cycle. res_valid rises 2 cycles after the qualified corr_finished edge.
- Lag arithmetic: zero-extend corr_maxIndex to IDX_W+1, then subtract N_SAMPLES-1 in two's complement. Range is -(N-1)..+(N-1). Index 3998 -> +1999; index 0 -> -1999.
- Boundary conditions:
  - start outside IDLE is ignored, with no queuing.
  - start and res_ack in the same PRESENT cycle: ack is honoured, start is dropped.
  - cap_done outside CAPTURE is ignored.
  - corr_finished and timeout on the same RUN cycle: finished wins (go to LATCH, no error).
  - Timeout counter saturates; it cannot wrap.
  - Reset asserted mid-operation returns immediately (asynchronously) to reset values; the correlator sees topState 000.
  - res_peak and res_lag hold their last value until the next LATCH, including through ABORT.

Optional Feature:
AUTO_RERUN_EN
- Defined: in PRESENT, res_ack moves to CLEAR instead of IDLE, giving continuous back-to-back measurements until start is seen low on the ack cycle. ABORT also returns to CLEAR, and timeout_err stays set until the next successful LATCH.
- Undefined: single-shot behaviour exactly as above.

Test Plan:
- Reset mid-RUN: assert reset at RUN cycle 100 -> topState 000 and busy 0 in the same cycle; state IDLE after release.
- Nominal pass: start; cap_done after 50 cycles; corr_finished at RUN cycle 10; maxResult 36'h0_0012_3456; maxIndex 2100.
  - Required response: res_valid 2 cycles later, res_peak 36'h0_0012_3456, res_lag +101.
  - res_ack -> IDLE, res_valid 0.
- Lag extremes: maxIndex 0 -> res_lag -1999 (13'h1831); maxIndex 3998 -> res_lag +1999 (13'h07CF).
- Stale finished: corr_finished held high from IDLE through CAPTURE -> no LATCH before RUN cycle 2; topState is 000 for exactly 4 cycles in CLEAR.
- Timeout: with TIMEOUT_CYCLES overridden to 16 and no finished -> ABORT after 16 RUN cycles; timeout_err 1; res_valid never asserts; next start clears timeout_err.
- Collisions: start during RUN is ignored; finished and timeout on the same cycle -> LATCH with timeout_err 0; start+ack in PRESENT -> IDLE, no new run (AUTO_RERUN_EN undefined).

Source files
------------

// File: rtl/corr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : corr_sequencer
// Brief    : Clears, captures and runs the delay correlator, then presents the
//            latched peak and its signed lag over a valid/ack handshake.
//            Optional macro AUTO_RERUN_EN enables back-to-back measurements.
// Revision : 1.0 - initial release
// ============================================================================
module corr_sequencer #(
  parameter int               N_SAMPLES      = 2000,
  parameter int               IDX_W          = 12,
  parameter int               RES_W          = 36,
  parameter int               TMO_W          = 24,
  parameter logic [TMO_W-1:0] TIMEOUT_CYCLES = 24'd9000000,
  parameter int               CLEAR_CYCLES   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             cap_req,
  input  logic             cap_done,
  output logic [2:0]       topState,
  input  logic             corr_finished,
  input  logic [RES_W-1:0] corr_maxResult,
  input  logic [IDX_W-1:0] corr_maxIndex,
  output logic             res_valid,
  input  logic             res_ack,
  output logic [RES_W-1:0] res_peak,
  output logic [IDX_W:0]   res_lag,
  output logic             busy,
  output logic             timeout_err
);

  localparam logic [2:0]       c_TOP_CLEAR = 3'b000;
  localparam logic [2:0]       c_TOP_HOLD  = 3'b001;
  localparam logic [2:0]       c_TOP_RUN   = 3'b010;
  localparam logic [TMO_W-1:0] c_CLR_LAST  = TMO_W'(CLEAR_CYCLES - 1);
  localparam logic [TMO_W-1:0] c_TMO_LAST  = TIMEOUT_CYCLES - TMO_W'(1);
  localparam logic [TMO_W-1:0] c_FIN_QUAL  = TMO_W'(2);
  localparam logic [IDX_W:0]   c_LAG_OFS   = (IDX_W+1)'(N_SAMPLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_CAPTURE = 3'd2,
    S_RUN     = 3'd3,
    S_LATCH   = 3'd4,
    S_PRESENT = 3'd5,
    S_ABORT   = 3'd6
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [TMO_W-1:0] r_cnt;
  logic [2:0]       r_top;
  logic             r_cap;
  logic             r_busy;
  logic             r_valid;
  logic             r_terr;
  logic [RES_W-1:0] r_peak;
  logic [IDX_W:0]   r_lag;
  logic [2:0]       w_top;
  logic             w_cap;
  logic             w_busy;
  logic             w_valid;
  logic             w_fin_q;
  logic [IDX_W:0]   w_lag;

  // The first two RUN cycles may still see the previous run's finished flag.
  assign w_fin_q = corr_finished && (r_cnt >= c_FIN_QUAL);
  assign w_lag   = {1'b0, corr_maxIndex} - c_LAG_OFS;

  always_comb begin
    w_next  = r_state;
    w_top   = c_TOP_HOLD;
    w_cap   = 1'b0;
    w_busy  = 1'b1;
    w_valid = 1'b0;
    case (r_state)
      S_IDLE:    if (start) w_next = S_CLEAR;
      S_CLEAR:   if (r_cnt >= c_CLR_LAST) w_next = S_CAPTURE;
      S_CAPTURE: if (cap_done) w_next = S_RUN;
      S_RUN: begin
        if (w_fin_q)                  w_next = S_LATCH;
        else if (r_cnt >= c_TMO_LAST) w_next = S_ABORT;
      end
      S_LATCH:   w_next = S_PRESENT;
`ifdef AUTO_RERUN_EN
      S_PRESENT: if (res_ack) w_next = start ? S_CLEAR : S_IDLE;
      S_ABORT:   w_next = S_CLEAR;
`else
      S_PRESENT: if (res_ack) w_next = S_IDLE;
      S_ABORT:   w_next = S_IDLE;
`endif
      default:   w_next = S_IDLE;
    endcase

    // Outputs are registered from the next state so they align with r_state.
    case (w_next)
      S_IDLE:           w_busy = 1'b0;
      S_CLEAR, S_ABORT: w_top  = c_TOP_CLEAR;
      S_CAPTURE:        w_cap  = 1'b1;
      S_RUN:            w_top  = c_TOP_RUN;
      S_PRESENT: begin
        w_busy  = 1'b0;
        w_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_top   <= c_TOP_CLEAR;
      r_cap   <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_top   <= w_top;
      r_cap   <= w_cap;
      r_busy  <= w_busy;
      r_valid <= w_valid;
      if (r_state != w_next)
        r_cnt <= '0;
      else if ((r_state == S_CLEAR || r_state == S_RUN) && r_cnt != '1)
        r_cnt <= r_cnt + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_peak <= '0;
      r_lag  <= '0;
      r_terr <= 1'b0;
    end else begin
      if (r_state == S_LATCH) begin
        r_peak <= corr_maxResult;
        r_lag  <= w_lag;
      end
`ifdef AUTO_RERUN_EN
      if (r_state == S_LATCH)
        r_terr <= 1'b0;
`else
      if (r_state == S_IDLE && start)
        r_terr <= 1'b0;
`endif
      else if (r_state == S_RUN && w_next == S_ABORT)
        r_terr <= 1'b1;
    end
  end

  assign topState    = r_top;
  assign cap_req     = r_cap;
  assign busy        = r_busy;
  assign res_valid   = r_valid;
  assign res_peak    = r_peak;
  assign res_lag     = r_lag;
  assign timeout_err = r_terr;

endmodule
`default_nettype wire
